// File: rtl/c2c_slave_decoder.sv
// Slave end of the chip2chip link: synchronises request, runs a 4-phase handshake and decodes data_in to a one-hot LED word.
// Optional build macro C2C_PARITY_EN adds even-parity checking (parity_in / parity_err).
module c2c_slave_decoder #(
  parameter int DATA_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int LED_W      = 2**DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic [DATA_W-1:0] data_in,
`ifdef C2C_PARITY_EN
  input  logic              parity_in,
  output logic              parity_err,
`endif
  output logic              ack,
  output logic [LED_W-1:0]  led,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic [LED_W-1:0]       r_led;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_req_s;
  logic                   w_accept;
  logic                   w_ack_nxt;
  logic [LED_W-1:0]       w_led_dec;

  assign w_req_s = r_sync[SYNC_STAGES-1];

  // request is the only asynchronous input; data_in is stable by the time LATCH samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], request};
    end
  end

`ifdef C2C_PARITY_EN
  logic r_parity_err;
  assign w_accept   = ((^data_in) == parity_in);
  assign parity_err = r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (r_state == S_LATCH && !w_accept) begin
      r_parity_err <= 1'b1;
    end
  end
`else
  assign w_accept = 1'b1;
`endif

  always_comb begin
    w_led_dec          = '0;
    w_led_dec[data_in] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    case (r_state)
      S_IDLE: begin
        w_ack_nxt = 1'b0;
        if (w_req_s) w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt = S_ACK;
        w_ack_nxt   = 1'b1;
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_nxt = S_IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Only LATCH touches led/xfer_cnt; a rejected code leaves both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
      r_cnt <= '0;
    end else if (r_state == S_LATCH && w_accept) begin
      r_led <= w_led_dec;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ack         = r_ack;
  assign led         = r_led;
  assign xfer_cnt    = r_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_c2c_slave_decoder.sv
// Bench for c2c_slave_decoder: directed handshake timing, sweep, long hold, short pulses, counter wrap, reset and parity.
module tb_c2c_slave_decoder;
  localparam int DATA_W = 3;
  localparam int CNT_W  = 8;
  localparam int LED_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              request = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ack;
  logic [LED_W-1:0]  led;
  logic [CNT_W-1:0]  xfer_cnt;
  logic [1:0]        dbg_state;
`ifdef C2C_PARITY_EN
  logic              parity_in = 1'b0;
  logic              parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [LED_W-1:0] exp_q[$];
  logic [LED_W-1:0] led_m = '0;
  logic [CNT_W-1:0] cnt_m = '0;

  c2c_slave_decoder #(.DATA_W(DATA_W), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .data_in     (data_in),
`ifdef C2C_PARITY_EN
    .parity_in   (parity_in),
    .parity_err  (parity_err),
`endif
    .ack         (ack),
    .led         (led),
    .xfer_cnt    (xfer_cnt),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    request = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    led_m = '0;
    cnt_m = '0;
  endtask

  task automatic wait_ack(input logic v, input int budget, input string tag);
    for (int i = 0; i < budget && ack !== v; i++) tick();
    check_eq(tag, 32'(ack), 32'(v));
  endtask

  // driver: one full 4-phase transfer; bad=1 sends wrong parity
  task automatic do_xfer(input int code, input bit bad, input int hold);
    logic [LED_W-1:0] e;
    data_in = DATA_W'(code);
`ifdef C2C_PARITY_EN
    parity_in = bad ? ~(^data_in) : (^data_in);
`endif
    request = 1'b1;
    e = bad ? led_m : (LED_W'(1) << code);
    exp_q.push_back(e);
    led_m = e;
    if (!bad) cnt_m++;
    wait_ack(1'b1, 12, "ack_rise");
    if (exp_q.size() > 0) check_eq("led", 32'(led), 32'(exp_q.pop_front()));
    check_eq("cnt", 32'(xfer_cnt), 32'(cnt_m));
    repeat (hold) tick();
    request = 1'b0;
    wait_ack(1'b0, 12, "ack_fall");
    check_eq("led_hold", 32'(led), 32'(led_m));
  endtask

  initial begin
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    do_reset();

    // idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_ack", 32'(ack), 32'd0);
      check_eq("idle_led", 32'(led), 32'd0);
      check_eq("idle_cnt", 32'(xfer_cnt), 32'd0);
    end
    check_eq("idle_state", 32'(dbg_state), 32'd0);

    // exact latency: ack/led/cnt at edge 3, ack falls at edge 2 of deassert
    data_in = 3'd5;
`ifdef C2C_PARITY_EN
    parity_in = ^data_in;
`endif
    request = 1'b1;
    tick(); tick(); tick();
    check_eq("lat_ack_e2", 32'(ack), 32'd0);
    check_eq("lat_led_e2", 32'(led), 32'd0);
    tick();
    check_eq("lat_ack_e3", 32'(ack), 32'd1);
    check_eq("lat_led_e3", 32'(led), 32'h20);
    check_eq("lat_cnt_e3", 32'(xfer_cnt), 32'd1);
    request = 1'b0;
    tick(); tick();
    check_eq("deas_ack_e1", 32'(ack), 32'd1);
    tick();
    check_eq("deas_ack_e2", 32'(ack), 32'd0);
    check_eq("deas_led", 32'(led), 32'h20);

    // sweep all codes from a clean counter
    do_reset();
    for (int c = 0; c < 8; c++) do_xfer(c, 1'b0, 0);
    check_eq("sweep_cnt", 32'(xfer_cnt), 32'd8);

    // long hold: one transfer only
    data_in = 3'd3;
`ifdef C2C_PARITY_EN
    parity_in = ^data_in;
`endif
    request = 1'b1;
    exp_q.push_back(8'h08);
    led_m = 8'h08;
    cnt_m++;
    wait_ack(1'b1, 12, "hold_rise");
    if (exp_q.size() > 0) check_eq("hold_led", 32'(led), 32'(exp_q.pop_front()));
    for (int i = 0; i < 50; i++) begin
      tick();
      check_eq("hold_ack", 32'(ack), 32'd1);
      check_eq("hold_cnt", 32'(xfer_cnt), 32'(cnt_m));
    end
    request = 1'b0;
    wait_ack(1'b0, 12, "hold_fall");

    // pulse between edges: missed
    data_in = 3'd6;
`ifdef C2C_PARITY_EN
    parity_in = ^data_in;
`endif
    #2 request = 1'b1;
    #3 request = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("miss_ack", 32'(ack), 32'd0);
    end
    check_eq("miss_cnt", 32'(xfer_cnt), 32'(cnt_m));

    // pulse across one edge: full transfer, request already low during LATCH
    request = 1'b1;
    exp_q.push_back(8'h40);
    led_m = 8'h40;
    cnt_m++;
    tick();
    request = 1'b0;
    wait_ack(1'b1, 12, "pulse_rise");
    if (exp_q.size() > 0) check_eq("pulse_led", 32'(led), 32'(exp_q.pop_front()));
    check_eq("pulse_cnt", 32'(xfer_cnt), 32'(cnt_m));
    tick();
    check_eq("pulse_ack_fall", 32'(ack), 32'd0);
    check_eq("pulse_state", 32'(dbg_state), 32'd0);

    // counter wrap with random codes
    do_reset();
    for (int i = 0; i < 257; i++) do_xfer($urandom_range(0, 7), 1'b0, $urandom_range(0, 2));
    check_eq("wrap_cnt", 32'(xfer_cnt), 32'd1);

`ifdef C2C_PARITY_EN
    do_reset();
    do_xfer(1, 1'b0, 0);
    check_eq("par_clean", 32'(parity_err), 32'd0);
    do_xfer(6, 1'b1, 0);
    check_eq("par_err", 32'(parity_err), 32'd1);
    check_eq("par_led", 32'(led), 32'h02);
    check_eq("par_cnt", 32'(xfer_cnt), 32'd1);
    do_xfer(4, 1'b0, 1);
    check_eq("par_sticky", 32'(parity_err), 32'd1);
    do_reset();
    check_eq("par_rst", 32'(parity_err), 32'd0);
`endif

    // reset while in ACK, request still high after release
    do_reset();
    data_in = 3'd7;
`ifdef C2C_PARITY_EN
    parity_in = ^data_in;
`endif
    request = 1'b1;
    wait_ack(1'b1, 12, "pre_rst_rise");
    check_eq("pre_rst_state", 32'(dbg_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    check_eq("mid_rst_led", 32'(led), 32'd0);
    check_eq("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    data_in = 3'd2;
`ifdef C2C_PARITY_EN
    parity_in = ^data_in;
`endif
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'h04);
    led_m = 8'h04;
    cnt_m = 8'd1;
    wait_ack(1'b1, 12, "post_rst_rise");
    if (exp_q.size() > 0) check_eq("post_rst_led", 32'(led), 32'(exp_q.pop_front()));
    check_eq("post_rst_cnt", 32'(xfer_cnt), 32'(cnt_m));
    request = 1'b0;
    wait_ack(1'b0, 12, "post_rst_fall");

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
